// File: rtl/systolic_setup.sv
// systolic_setup: aligns global-buffer words with controller strobes and skews lane j by j cycles
// to form the diagonal wavefront at the PE array edge; bubbles inject valid zeros so tails drain.
module systolic_setup #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 8,
  parameter int BUF_LAT    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ensys_i,
  input  logic                  bubble_i,
  input  logic [N*DATA_WIDTH-1:0] data_i,
  output logic [N*DATA_WIDTH-1:0] data_o,
  output logic [N-1:0]          valid_o,
  output logic                  busy_o
);
  logic [BUF_LAT-1:0] en_q, en_d, bub_q, bub_d;
  logic               en_a, bub_a, elem_valid;
  logic [N-1:0]       lane_busy;

  always_comb begin
    en_d  = (en_q << 1) | BUF_LAT'(ensys_i);
    bub_d = (bub_q << 1) | BUF_LAT'(bubble_i);
  end

  assign en_a       = en_q[BUF_LAT-1];
  assign bub_a      = bub_q[BUF_LAT-1];
  assign elem_valid = en_a | bub_a;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q  <= '0;
      bub_q <= '0;
    end else begin
      en_q  <= en_d;
      bub_q <= bub_d;
    end
  end

  // Lane j is a (j+1)-stage shift register; stage 0 sits in the LSBs, the output stage in the MSBs.
  for (genvar j = 0; j < N; j++) begin : g_lane
    localparam int LW = (j + 1) * DATA_WIDTH;
    localparam int VW = j + 1;
    logic [DATA_WIDTH-1:0] elem;
    logic [LW-1:0]         dat_q, dat_d;
    logic [VW-1:0]         vld_q, vld_d;

    always_comb begin
      elem  = en_a ? data_i[j*DATA_WIDTH +: DATA_WIDTH] : '0;
      dat_d = (dat_q << DATA_WIDTH) | LW'(elem);
      vld_d = (vld_q << 1) | VW'(elem_valid);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        dat_q <= '0;
        vld_q <= '0;
      end else begin
        dat_q <= dat_d;
        vld_q <= vld_d;
      end
    end

    assign data_o[j*DATA_WIDTH +: DATA_WIDTH] = dat_q[LW-1 -: DATA_WIDTH];
    assign valid_o[j]                         = vld_q[VW-1];
    assign lane_busy[j]                       = |vld_q;
  end

  assign busy_o = |{en_q, bub_q, lane_busy};
endmodule

// File: tb/tb_systolic_setup.sv
// tb_systolic_setup: randomized and directed checks of two builds (BUF_LAT=1 and 2) against a
// cycle-history model: lane j at cycle c shows the strobe of cycle c-L-1-j with data from c-1-j.
module tb_systolic_setup;
  localparam int N = 8;
  localparam int DW = 8;
  localparam int HN = 4096;

  logic clk = 1'b0;
  logic rst_ni, ensys_i, bubble_i;
  logic [N*DW-1:0] data_i, data_o1, data_o2;
  logic [N-1:0] valid_o1, valid_o2;
  logic busy_o1, busy_o2;

  int cyc = 0;
  int start = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit done = 1'b0;
  bit h_en [HN];
  bit h_bub [HN];
  logic [N*DW-1:0] h_din [HN];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_setup #(.N(N), .DATA_WIDTH(DW), .BUF_LAT(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .ensys_i(ensys_i), .bubble_i(bubble_i),
    .data_i(data_i), .data_o(data_o1), .valid_o(valid_o1), .busy_o(busy_o1));

  systolic_setup #(.N(N), .DATA_WIDTH(DW), .BUF_LAT(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_ni), .ensys_i(ensys_i), .bubble_i(bubble_i),
    .data_i(data_i), .data_o(data_o2), .valid_o(valid_o2), .busy_o(busy_o2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic void model(input int lat, input int c, output logic [63:0] d,
                                output logic [7:0] v, output logic b);
    d = '0;
    v = '0;
    b = 1'b0;
    for (int j = 0; j < N; j++) begin
      int t = c - lat - 1 - j;
      if (t >= start && (h_en[t] || h_bub[t])) begin
        v[j] = 1'b1;
        if (h_en[t]) d[j*DW +: DW] = h_din[t+lat][j*DW +: DW];
      end
    end
    for (int t = c - lat - N; t < c; t++)
      if (t >= start && (h_en[t] || h_bub[t])) b = 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!done) begin
      logic [63:0] d1, d2;
      logic [7:0] v1, v2;
      logic b1, b2;
      if (!rst_ni) begin
        d1 = '0; v1 = '0; b1 = 1'b0;
        d2 = '0; v2 = '0; b2 = 1'b0;
      end else begin
        model(1, cyc, d1, v1, b1);
        model(2, cyc, d2, v2, b2);
      end
      chk("l1_data", data_o1, d1);
      chk("l1_valid", 64'(valid_o1), 64'(v1));
      chk("l1_busy", 64'(busy_o1), 64'(b1));
      chk("l2_data", data_o2, d2);
      chk("l2_valid", 64'(valid_o2), 64'(v2));
      chk("l2_busy", 64'(busy_o2), 64'(b2));
    end
  end

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic step(input bit e, input bit b, input logic [63:0] d);
    @(posedge clk);
    #1;
    ensys_i  = e;
    bubble_i = b;
    data_i   = d;
    if (cyc < HN) begin
      h_en[cyc]  = e;
      h_bub[cyc] = b;
      h_din[cyc] = d;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rnd64());
  endtask

  task automatic do_reset();
    #2;
    rst_ni   = 1'b0;
    ensys_i  = 1'b0;
    bubble_i = 1'b0;
    #1;
    chk("rst_data1", data_o1, 64'h0);
    chk("rst_valid1", 64'(valid_o1), 64'h0);
    chk("rst_busy1", 64'(busy_o1), 64'h0);
    chk("rst_data2", data_o2, 64'h0);
    chk("rst_valid2", 64'(valid_o2), 64'h0);
    chk("rst_busy2", 64'(busy_o2), 64'h0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    start  = cyc;
  endtask

  initial begin
    logic [7:0] ev;
    logic [7:0] bv;
    int dens;
    rst_ni = 1'b0; ensys_i = 1'b0; bubble_i = 1'b0; data_i = '0;
    for (int i = 0; i < HN; i++) h_din[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    start  = cyc;
    idle(5);

    for (int k = 0; k < 26; k++) begin
      step(k == 10, 1'b0, (k == 11) ? 64'h0807060504030201 : rnd64());
      ev = (k >= 12 && k <= 19) ? (8'd1 << (k - 12)) : 8'd0;
      chk("sw_valid", 64'(valid_o1), 64'(ev));
      if (k >= 12 && k <= 19) chk("sw_lane", 64'(data_o1[(k-12)*DW +: DW]), 64'(k - 11));
      chk("sw_busy", 64'(busy_o1), 64'(k >= 11 && k <= 19));
      if (k == 13) chk("bl2_lane0", 64'(valid_o2), 64'h01);
      if (k == 20) chk("bl2_lane7", 64'(valid_o2), 64'h80);
    end
    idle(15);

    for (int k = 0; k < 26; k++) begin
      bv = 8'(k - 11);
      step(k >= 10 && k <= 17, 1'b0, (k >= 11 && k <= 18) ? {8{bv}} : rnd64());
      if (k == 17) begin
        chk("st_data", data_o1, 64'h0000000102030405);
        chk("st_valid", 64'(valid_o1), 64'h3F);
      end
    end
    idle(15);

    for (int k = 0; k < 30; k++) begin
      step(k >= 10 && k <= 12, k >= 13 && k <= 17, rnd64());
      if (k == 20) begin
        chk("bd_l5_valid", 64'(valid_o1[5]), 64'h1);
        chk("bd_l5_data", 64'(data_o1[5*DW +: DW]), 64'h0);
      end
      if (k == 26) chk("bd_tail", 64'(valid_o1), 64'h80);
      if (k == 27) begin
        chk("bd_drained", 64'(valid_o1), 64'h0);
        chk("bd_busy", 64'(busy_o1), 64'h0);
      end
    end
    idle(15);

    for (int k = 0; k < 26; k++) begin
      step(k == 10, k == 10, (k == 11) ? 64'h1122334455667788 : 64'hFFFFFFFFFFFFFFFF);
      if (k == 5 || k == 25) chk("idle_zero", data_o1, 64'h0);
      if (k == 12) begin
        chk("pri_valid", 64'(valid_o1), 64'h01);
        chk("pri_data", data_o1, 64'h88);
      end
    end
    idle(5);

    for (int k = 0; k < 14; k++) step(1'b1, k[0], rnd64());
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, rnd64());
      chk("post_rst_valid", 64'(valid_o1), 64'h0);
      chk("post_rst_busy", 64'(busy_o2), 64'h0);
    end

    dens = 50;
    for (int k = 0; k < 1500; k++) begin
      int r;
      if (k % 100 == 0) dens = $urandom_range(0, 100);
      r = $urandom_range(0, 99);
      step(r < dens, (r >= dens && r < dens + 15) || ($urandom_range(0, 9) == 0), rnd64());
      if (k % 500 == 250) do_reset();
    end
    idle(20);

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
